// File: rtl/f51m_arbiter.sv
// Round-robin front end that shares one combinational f51m datapath among NREQ
// requesters, with one operation in flight: IDLE (grant) -> ISSUE -> RESP (handshake).
module f51m_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = 16
) (
  input  logic              clk_pad,
  input  logic              rst_pad,
  input  logic [NREQ-1:0]   req_valid_pad,
  input  logic [8*NREQ-1:0] req_data_pad,
  output logic [NREQ-1:0]   req_ready_pad,
  output logic [7:0]        dp_in_pad,
  input  logic [7:0]        dp_out_pad,
  output logic              rsp_valid_pad,
  output logic [IDW-1:0]    rsp_id_pad,
  output logic [7:0]        rsp_data_pad,
  input  logic              rsp_ready_pad,
  output logic              busy_pad,
  output logic [CNTW-1:0]   done_cnt_pad
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id_reg;
  logic [7:0]      op_reg;
  logic [IDW-1:0]  grant_id;
  logic            grant_vld;
  logic [IDW:0]    sum;
  logic [IDW-1:0]  idx;
  logic [7:0]      req_op [NREQ];
  logic            accept;
  logic            complete;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_op[i] = req_data_pad[8*i +: 8];
    end
  end

  // Round-robin search: first valid requester at or above ptr, wrapping past NREQ-1.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (!grant_vld && req_valid_pad[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

  assign accept   = (state == IDLE) && grant_vld && !rst_pad;
  assign complete = (state == RESP) && rsp_ready_pad;

  always_comb begin
    req_ready_pad = '0;
    if (accept) req_ready_pad[grant_id] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready_pad) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_pad or posedge rst_pad) begin
    if (rst_pad) state <= IDLE;
    else         state <= state_nxt;
  end

  // Operand capture: the datapath sees op_reg for the whole ISSUE cycle.
  always_ff @(posedge clk_pad or posedge rst_pad) begin
    if (rst_pad) begin
      op_reg <= '0;
      id_reg <= '0;
    end else if (accept) begin
      op_reg <= req_op[grant_id];
      id_reg <= grant_id;
    end
  end

  // Result capture at the end of ISSUE; held until the downstream handshake.
  always_ff @(posedge clk_pad or posedge rst_pad) begin
    if (rst_pad) rsp_data_pad <= '0;
    else if (state == ISSUE) rsp_data_pad <= dp_out_pad;
  end

  // Priority moves only on completion, so an abandoned operation keeps its slot.
  always_ff @(posedge clk_pad or posedge rst_pad) begin
    if (rst_pad) begin
      ptr          <= '0;
      done_cnt_pad <= '0;
    end else if (complete) begin
      ptr <= (id_reg == IDW'(NREQ-1)) ? '0 : id_reg + 1'b1;
      if (done_cnt_pad != {CNTW{1'b1}}) done_cnt_pad <= done_cnt_pad + CNTW'(1);
    end
  end

  assign dp_in_pad     = op_reg;
  assign rsp_valid_pad = (state == RESP);
  assign rsp_id_pad    = id_reg;
  assign busy_pad      = (state != IDLE);

endmodule

// File: tb/tb_f51m_arbiter.sv
// Directed bench for f51m_arbiter with a simple XOR stand-in for the f51m datapath.
module tb_f51m_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 4;
  localparam logic [7:0] OPV [4] = '{8'h5A, 8'h81, 8'h3C, 8'hC3};

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        dp_in;
  logic [7:0]        dp_out;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_data;
  logic              rsp_ready;
  logic              busy;
  logic [CNTW-1:0]   done_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  f51m_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk_pad       (clk),
    .rst_pad       (rst),
    .req_valid_pad (req_valid),
    .req_data_pad  (req_data),
    .req_ready_pad (req_ready),
    .dp_in_pad     (dp_in),
    .dp_out_pad    (dp_out),
    .rsp_valid_pad (rsp_valid),
    .rsp_id_pad    (rsp_id),
    .rsp_data_pad  (rsp_data),
    .rsp_ready_pad (rsp_ready),
    .busy_pad      (busy),
    .done_cnt_pad  (done_cnt)
  );

  assign dp_out = dp_in ^ 8'hA5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run_op(input logic [NREQ-1:0] mask, input int id);
    req_valid = mask;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("grant", 32'(req_ready), 32'(1 << id));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("dp_in", 32'(dp_in), 32'(OPV[id]));
    check("rsp_valid_issue", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_id", 32'(rsp_id), 32'(id));
    check("rsp_data", 32'(rsp_data), 32'(OPV[id] ^ 8'hA5));
    @(posedge clk); #1;
    if (exp_cnt != 15) exp_cnt++;
    check("done_cnt", 32'(done_cnt), 32'(exp_cnt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_data  = {OPV[3], OPV[2], OPV[1], OPV[0]};

    // Reset state, including ready suppressed while reset is held
    @(posedge clk); #1;
    req_valid = 4'b0010;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_done", 32'(done_cnt), 32'd0);
    check("rst_dp_in", 32'(dp_in), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b0;

    // Single request from requester 0 with operand 0x5A
    run_op(4'b0001, 0);
    check("single_data", 32'(rsp_data), 32'hFF);

    // All requesters valid: grants 0,1,2,3,0 every third cycle
    do_reset();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      check("rr_ready", 32'(req_ready), (c % 3 == 0) ? 32'(1 << ((c / 3) % 4)) : 32'd0);
      if (c % 3 == 2) begin
        check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rr_rsp_id", 32'(rsp_id), 32'((c / 3) % 4));
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    exp_cnt = 5;
    check("rr_done", 32'(done_cnt), 32'd5);

    // Backpressure on requester 2 (ptr is now 1)
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    @(negedge clk);
    check("bp_grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid = 4'b1111;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_id", 32'(rsp_id), 32'd2);
      check("bp_rsp_data", 32'(rsp_data), 32'h99);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_rsp_valid_end", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    exp_cnt++;
    check("bp_done", 32'(done_cnt), 32'(exp_cnt));
    check("bp_idle", 32'(busy), 32'd0);

    // Wrap: ptr 3 -> requester 1, then with ptr 2 requesters 3 then 1
    run_op(4'b0010, 1);
    run_op(4'b1010, 3);
    run_op(4'b1010, 1);

    // Asynchronous reset in RESP abandons the operation (ptr 2 -> grant 0)
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    @(negedge clk);
    check("ar_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("ar_rsp_valid_pre", 32'(rsp_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_rsp_valid", 32'(rsp_valid), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_done", 32'(done_cnt), 32'd0);
    check("ar_rsp_data", 32'(rsp_data), 32'd0);
    check("ar_dp_in", 32'(dp_in), 32'd0);
    req_valid = 4'b1111;
    #1;
    check("ar_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    check("ar_no_rsp", 32'(rsp_valid), 32'd0);
    check("ar_done_after", 32'(done_cnt), 32'd0);
    @(posedge clk); #1;
    run_op(4'b1100, 2);

    // Saturation of the 4-bit completion counter
    for (int i = 0; i < 20; i++) begin
      run_op(4'b1111, (3 + i) % 4);
    end
    check("sat_done", 32'(done_cnt), 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
